// File: rtl/mul_feeder.sv
// mul_feeder: operand queue and sequencer in front of the multi-cycle 8x8
// multiplier. Operand pairs arrive on a valid/ready stream and are buffered
// in a small FIFO. They are issued one at a time over the multiplier's
// start/busy handshake. Each 16-bit product is held on a valid/ready output
// until it is taken. Only one product can be in flight at a time, so results
// leave in FIFO order and none is ever dropped.
module mul_feeder #(
    parameter int DEPTH = 4,   // operand FIFO depth in pairs, power of two >= 2
    parameter int AW    = 2    // log2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    a_bi,
    input  logic [7:0]    b_bi,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [15:0]   y_bo,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [7:0]    mul_a_bo,
    output logic [7:0]    mul_b_bo,
    output logic          mul_start_o,
    input  logic          mul_busy_i,
    input  logic [15:0]   mul_y_bi,
    output logic [AW:0]   count_bo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state_q;
    state_t        state_d;

    // Operand storage: {a, b} per entry, head at rd_ptr.
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   head;

    // Per-cycle strobes derived from the current state.
    logic          push;
    logic          pop;
    logic          issue_go;
    logic          cap_y;
    logic          deliver;
    logic          start_d;
    logic          valid_d;

    // Full when count reaches DEPTH; depends only on the count register.
    assign ready_o = (count_bo != FULL_CNT);
    assign push    = valid_i && ready_o;
    assign head    = mem[rd_ptr];

    // FIFO storage write: data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {a_bi, b_bi};
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop moves both
    // pointers and leaves the count unchanged. Pointers wrap naturally
    // because DEPTH is a power of two. A pop only happens in ISSUE, and ISSUE
    // is only entered with a non-empty FIFO, so the count cannot underflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_bo <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_bo <= count_bo + 1'b1;
                2'b01:   count_bo <= count_bo - 1'b1;
                default: count_bo <= count_bo;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((count_bo != '0) && !mul_busy_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mul_busy_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer output decode: the strobes and the next values of the
    // registered handshake outputs.
    always_comb begin
        issue_go = 1'b0;
        pop      = 1'b0;
        cap_y    = 1'b0;
        deliver  = 1'b0;
        case (state_q)
            ST_IDLE:  issue_go = (count_bo != '0) && !mul_busy_i;
            ST_ISSUE: pop      = 1'b1;
            ST_WAIT:  cap_y    = !mul_busy_i;
            ST_HOLD:  deliver  = ready_i;
            default:  ;
        endcase
        // The start pulse lasts exactly the ISSUE cycle: it is raised on
        // IDLE->ISSUE and drops on ISSUE->WAIT.
        start_d = issue_go;
        // The product stays valid from capture until the output handshake.
        valid_d = cap_y || (valid_o && !deliver);
    end

    // Registered outputs toward the multiplier and the result stream.
    // The operands hold their last issued value outside ISSUE, because the
    // multiplier may still sample them while it is busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mul_start_o <= 1'b0;
            mul_a_bo    <= '0;
            mul_b_bo    <= '0;
            valid_o     <= 1'b0;
            y_bo        <= '0;
        end else begin
            mul_start_o <= start_d;
            valid_o     <= valid_d;
            if (issue_go) begin
                mul_a_bo <= head[15:8];
                mul_b_bo <= head[7:0];
            end
            if (cap_y) begin
                y_bo <= mul_y_bi;
            end
        end
    end

endmodule
